// File: rtl/mvm_pkg.sv
// Shared constants and FSM encoding for the mvm_4_1_8_1 job feeder.
// Pure declarations: no latency, no backpressure.
package mvm_pkg;
  localparam int K      = 4;
  localparam int B      = 8;
  localparam int N_MAT  = K * K;
  localparam int N_FULL = K * K + K;
  localparam int CNT_W  = $clog2(N_FULL + 1);

  typedef enum logic [3:0] {
    IDLE,
    FILL,
    LOADM,
    SENDM,
    GAPM,
    LOADV,
    SENDV,
    GAPV,
    START,
    WAITD,
    DRAIN
  } feeder_state_t;
endpackage

// File: rtl/mvm_elem_buf.sv
// One-job element store: single write port, combinational read port, no reset.
// Write lands on the next clk edge; read is same-cycle; never stalls.
import mvm_pkg::*;

module mvm_elem_buf (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_addr,
  input  logic [B-1:0]     wr_data,
  input  logic [CNT_W-1:0] rd_addr,
  output logic [B-1:0]     rd_data
);
  logic [B-1:0] mem [N_FULL];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/mvm_feeder.sv
// Buffers one matrix/vector job, replays it gap-free to the multiplier, then waits done + K drain cycles.
// Burst starts 1 cycle after the last beat; in_ready is low from the last beat until job_done.
import mvm_pkg::*;

module mvm_feeder (
  input  logic         clk,
  input  logic         reset,
  input  logic [B-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         keep_matrix,
  output logic [B-1:0] mvm_data,
  output logic         mvm_loadMatrix,
  output logic         mvm_loadVector,
  output logic         mvm_start,
  input  logic         mvm_done,
  output logic         busy,
  output logic         job_done
);
  feeder_state_t    state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic             keep, nxt_keep;
  logic             matrix_valid;
  logic             set_mv;
  logic             accept;
  logic [CNT_W-1:0] n_job;
  logic [CNT_W-1:0] rd_addr;
  logic [B-1:0]     rd_data;

  assign accept = in_valid & in_ready;
  assign n_job  = keep ? CNT_W'(K) : CNT_W'(N_FULL);

  mvm_elem_buf u_buf (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (cnt),
    .wr_data (in_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_keep  = keep;
    set_mv    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          nxt_keep = keep_matrix & matrix_valid;
          nxt_cnt  = CNT_W'(1);
          // A one-element vector-only job is complete with its first beat.
          if (nxt_keep && (K == 1)) begin
            nxt_state = LOADV;
            nxt_cnt   = '0;
          end else begin
            nxt_state = FILL;
          end
        end
      end
      FILL: begin
        if (accept) begin
          nxt_cnt = cnt + CNT_W'(1);
          if (nxt_cnt == n_job) begin
            nxt_state = keep ? LOADV : LOADM;
            nxt_cnt   = '0;
          end
        end
      end
      LOADM: begin
        nxt_state = SENDM;
        nxt_cnt   = '0;
      end
      SENDM: begin
        if (cnt == CNT_W'(N_MAT - 1)) begin
          nxt_state = GAPM;
          nxt_cnt   = '0;
          set_mv    = 1'b1;
        end else begin
          nxt_cnt = cnt + CNT_W'(1);
        end
      end
      GAPM:  nxt_state = LOADV;
      LOADV: begin
        nxt_state = SENDV;
        nxt_cnt   = '0;
      end
      SENDV: begin
        if (cnt == CNT_W'(K - 1)) begin
          nxt_state = GAPV;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + CNT_W'(1);
        end
      end
      GAPV:  nxt_state = START;
      START: nxt_state = WAITD;
      WAITD: begin
        if (mvm_done) begin
          nxt_state = DRAIN;
          nxt_cnt   = '0;
        end
      end
      DRAIN: begin
        if (cnt == CNT_W'(K - 1)) begin
          nxt_state = IDLE;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + CNT_W'(1);
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state, so the read address follows the next count.
  always_comb begin
    rd_addr = '0;
    if (nxt_state == SENDM) rd_addr = nxt_cnt;
    else if (nxt_state == SENDV) rd_addr = keep ? nxt_cnt : CNT_W'(N_MAT) + nxt_cnt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      keep           <= 1'b0;
      matrix_valid   <= 1'b0;
      in_ready       <= 1'b0;
      busy           <= 1'b0;
      mvm_loadMatrix <= 1'b0;
      mvm_loadVector <= 1'b0;
      mvm_start      <= 1'b0;
      mvm_data       <= '0;
      job_done       <= 1'b0;
    end else begin
      state          <= nxt_state;
      cnt            <= nxt_cnt;
      keep           <= nxt_keep;
      if (set_mv) matrix_valid <= 1'b1;
      in_ready       <= (nxt_state == IDLE) || (nxt_state == FILL);
      busy           <= (nxt_state != IDLE);
      mvm_loadMatrix <= (nxt_state == LOADM);
      mvm_loadVector <= (nxt_state == LOADV);
      mvm_start      <= (nxt_state == START);
      mvm_data       <= ((nxt_state == SENDM) || (nxt_state == SENDV)) ? rd_data : '0;
      job_done       <= (state == DRAIN) && (nxt_state == IDLE);
    end
  end
endmodule

// File: tb/tb_mvm_feeder.sv
// Randomised job stream against a cycle-timeline model of the feeder plus a multiplier stand-in.
// The stand-in answers each start with done after 2..6 cycles and computes y from the captured bursts.
module tb_mvm_feeder;
  import mvm_pkg::*;

  logic         clk;
  logic         reset;
  logic [B-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         keep_matrix;
  logic [B-1:0] mvm_data;
  logic         mvm_loadMatrix;
  logic         mvm_loadVector;
  logic         mvm_start;
  logic         mvm_done;
  logic         busy;
  logic         job_done;
  logic         real_done = 1'b0;
  logic         spur_done = 1'b0;

  assign mvm_done = real_done | spur_done;

  mvm_feeder dut (
    .clk            (clk),
    .reset          (reset),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .keep_matrix    (keep_matrix),
    .mvm_data       (mvm_data),
    .mvm_loadMatrix (mvm_loadMatrix),
    .mvm_loadVector (mvm_loadVector),
    .mvm_start      (mvm_start),
    .mvm_done       (mvm_done),
    .busy           (busy),
    .job_done       (job_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  // Multiplier stand-in: done some cycles after start.
  int wait_lat = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_lat  = 0;
      real_done = 1'b0;
    end else begin
      #1;
      real_done = 1'b0;
      if (mvm_start) wait_lat = $urandom_range(2, 6);
      else if (wait_lat > 0) begin
        wait_lat--;
        if (wait_lat == 0) real_done = 1'b1;
      end
    end
  end

  // Behavioural model: phase 0 idle, 1 filling, 2 burst/wait, 3 drain.
  int ph = 0, rel = 0, dcnt = 0, got = 0, need = 0, cyc = 0, last_acc = 0;
  int beats = 0, lm_cnt = 0, cap_mode = 0, cap_i = 0, exp_gap = 0;
  bit mv = 0, keep_j = 0, fresh = 1, jd = 0, y_chk = 0;
  logic [7:0]        job [N_FULL];
  logic signed [7:0] cmat [N_MAT];
  logic signed [7:0] cvec [K];
  int exp_y [K];

  function automatic void exp_burst(input int r, output bit lm, output bit lv, output bit st, output int d);
    int base;
    base = keep_j ? 0 : N_MAT + 2;
    lm = 0; lv = 0; st = 0; d = 0;
    if (!keep_j && r == 1) lm = 1;
    if (!keep_j && r >= 2 && r <= N_MAT + 1) d = int'(job[r-2]);
    if (r == base + 1) lv = 1;
    if (r >= base + 2 && r <= base + K + 1) d = int'(job[(keep_j ? 0 : N_MAT) + r - base - 2]);
    if (r == base + K + 3) st = 1;
  endfunction

  always @(negedge clk) begin
    bit e_ir, e_busy, e_lm, e_lv, e_st, acc;
    int e_d, y;
    cyc++;
    if (!reset) begin
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_loadM", int'(mvm_loadMatrix), 0);
      chk("rst_loadV", int'(mvm_loadVector), 0);
      chk("rst_start", int'(mvm_start), 0);
      chk("rst_data", int'(mvm_data), 0);
      chk("rst_job_done", int'(job_done), 0);
      ph = 0; mv = 0; fresh = 1; jd = 0; cap_mode = 0;
    end else begin
      if (ph == 2) rel++;
      e_ir = !fresh && (ph <= 1);
      e_busy = (ph != 0);
      e_lm = 0; e_lv = 0; e_st = 0; e_d = 0;
      if (ph == 2) exp_burst(rel, e_lm, e_lv, e_st, e_d);
      chk("in_ready", int'(in_ready), int'(e_ir));
      chk("busy", int'(busy), int'(e_busy));
      chk("loadMatrix", int'(mvm_loadMatrix), int'(e_lm));
      chk("loadVector", int'(mvm_loadVector), int'(e_lv));
      chk("start", int'(mvm_start), int'(e_st));
      chk("mvm_data", int'(mvm_data), e_d);
      chk("job_done", int'(job_done), int'(jd));
      fresh = 0;
      jd = 0;

      if (cap_mode == 1) begin
        cmat[cap_i] = mvm_data; cap_i++;
        if (cap_i == N_MAT) cap_mode = 0;
      end else if (cap_mode == 2) begin
        cvec[cap_i] = mvm_data; cap_i++;
        if (cap_i == K) cap_mode = 0;
      end
      if (mvm_loadMatrix) begin cap_mode = 1; cap_i = 0; lm_cnt++; end
      if (mvm_loadVector) begin cap_mode = 2; cap_i = 0; end
      if (mvm_start && y_chk) begin
        for (int r = 0; r < K; r++) begin
          y = 0;
          for (int c = 0; c < K; c++) y += int'(cmat[r*K+c]) * int'(cvec[c]);
          chk($sformatf("y%0d", r), y, exp_y[r]);
        end
        chk("start_gap", cyc - last_acc, exp_gap);
        y_chk = 0;
      end
      if (in_valid && in_ready) beats++;

      acc = in_valid && e_ir;
      case (ph)
        0: if (acc) begin
          keep_j = keep_matrix && mv;
          need = keep_j ? K : N_FULL;
          job[0] = in_data;
          got = 1;
          if (got == need) begin ph = 2; rel = 0; last_acc = cyc; end
          else ph = 1;
        end
        1: if (acc) begin
          job[got] = in_data;
          got++;
          if (got == need) begin ph = 2; rel = 0; last_acc = cyc; end
        end
        2: begin
          if (!keep_j && rel == N_MAT + 1) mv = 1;
          if (rel >= (keep_j ? K + 4 : N_FULL + 6) && mvm_done) begin ph = 3; dcnt = 0; end
        end
        3: begin
          dcnt++;
          if (dcnt == K) begin ph = 0; jd = 1; end
        end
        default: ph = 0;
      endcase
    end
  end

  // Stimulus
  logic signed [7:0] jobbuf [N_FULL];
  logic signed [7:0] last_mat [N_MAT];

  task automatic load_plan(input int vec_val0, input int vec_rest);
    for (int i = 0; i < N_MAT; i++) jobbuf[i] = 8'(i + 1);
    for (int i = 0; i < K; i++) jobbuf[N_MAT+i] = 8'((i == 0) ? vec_val0 : vec_rest);
  endtask

  task automatic load_random();
    for (int i = 0; i < N_FULL; i++) jobbuf[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic compute_exp(input bit vec_only);
    int y;
    if (!vec_only) for (int i = 0; i < N_MAT; i++) last_mat[i] = jobbuf[i];
    for (int r = 0; r < K; r++) begin
      y = 0;
      for (int c = 0; c < K; c++)
        y += int'(last_mat[r*K+c]) * int'(vec_only ? jobbuf[c] : jobbuf[N_MAT+c]);
      exp_y[r] = y;
    end
    exp_gap = vec_only ? K + 3 : N_FULL + 5;
  endtask

  task automatic send_job(input bit kp, input int n, input int gap, input bit spur);
    int i, c, it;
    bit acc;
    i = 0; c = 0; it = 0; acc = 0;
    while (i < n && it < 1000) begin
      @(posedge clk); #1;
      spur_done = spur && (it == 4);
      if (acc) begin in_valid = 0; acc = 0; end
      if (!in_valid) begin
        if (c % gap == 0) begin
          in_valid = 1; in_data = jobbuf[i]; keep_matrix = kp;
        end
        c++;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin acc = 1; i++; end
      it++;
    end
    @(posedge clk); #1;
    in_valid = 0; spur_done = 0; keep_matrix = 0;
    if (i < n) fail("send_timeout");
  endtask

  task automatic wait_jd(input string nm);
    int t;
    t = 0;
    while (!job_done && t < 500) begin @(negedge clk); t++; end
    if (!job_done) fail(nm);
  endtask

  task automatic set_lit_y(input int a, input int b, input int c, input int d);
    exp_y[0] = a; exp_y[1] = b; exp_y[2] = c; exp_y[3] = d;
  endtask

  task automatic run_plan_full(input bit kp, input int gap, input string nm);
    load_plan(1, 1);
    compute_exp(0);
    set_lit_y(10, 26, 42, 58);
    exp_gap = 25;
    y_chk = 1; beats = 0; lm_cnt = 0;
    send_job(kp, N_FULL, gap, 0);
    wait_jd(nm);
    chk({nm, "_beats"}, beats, 20);
    chk({nm, "_loadM"}, lm_cnt, 1);
  endtask

  initial begin
    int t;
    bit kp;
    in_valid = 0; in_data = 0; keep_matrix = 0; reset = 1;
    #2 reset = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    repeat (3) @(negedge clk);
    chk("idle_in_ready", int'(in_ready), 1);
    chk("idle_busy", int'(busy), 0);

    run_plan_full(1, 1, "keep_first");
    run_plan_full(0, 1, "full_cont");
    run_plan_full(0, 3, "full_gap3");

    load_plan(0, 0);
    jobbuf[0] = 8'sd2; jobbuf[1] = 0; jobbuf[2] = 0; jobbuf[3] = 0;
    compute_exp(1);
    set_lit_y(2, 10, 18, 26);
    exp_gap = 7;
    y_chk = 1; beats = 0; lm_cnt = 0;
    send_job(1, K, 1, 0);
    wait_jd("vec_only");
    chk("vec_only_beats", beats, 4);
    chk("vec_only_loadM", lm_cnt, 0);

    @(posedge clk); #1 spur_done = 1;
    @(posedge clk); #1 spur_done = 0;
    repeat (3) @(negedge clk);
    chk("spur_idle_busy", int'(busy), 0);

    load_random();
    compute_exp(0);
    y_chk = 1;
    send_job(0, N_FULL, 3, 1);
    wait_jd("spur_fill");

    for (int j = 0; j < 8; j++) begin
      kp = 1'($urandom_range(0, 1));
      load_random();
      compute_exp(kp);
      y_chk = 1;
      send_job(kp, kp ? K : N_FULL, $urandom_range(1, 3), 0);
      wait_jd("rand_job");
    end

    load_random();
    y_chk = 0;
    send_job(0, N_FULL, 1, 0);
    t = 0;
    while (!mvm_loadMatrix && t < 100) begin @(negedge clk); t++; end
    if (!mvm_loadMatrix) fail("wait_loadM");
    repeat (9) @(posedge clk);
    #3 reset = 0;
    @(negedge clk);
    chk("midrst_data", int'(mvm_data), 0);
    chk("midrst_busy", int'(busy), 0);
    @(posedge clk); #1 reset = 1;
    @(negedge clk);
    chk("rel_in_ready0", int'(in_ready), 0);
    @(negedge clk);
    chk("rel_in_ready1", int'(in_ready), 1);

    run_plan_full(1, 2, "keep_after_rst");

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    fail("watchdog");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/mvm_feeder.md
# mvm_feeder

Upstream sequencer for the `mvm_4_1_8_1` matrix-vector multiplier. It accepts a gapped valid/ready stream of signed elements and buffers one job (matrix then vector). It then replays that job to the multiplier as gap-free load bursts, pulses start, and waits for done. It then holds off the next job for the K result-drain cycles. This guarantees the multiplier always sees the back-to-back element timing it requires, regardless of upstream stalls.

## Interface
- `K`, 4, matrix dimension (K×K matrix, K-vector)
- `B`, 8, element width in bits (signed)
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `in_data` in B: signed input element
- `in_valid` in 1: `in_data` valid
- `in_ready` out 1: feeder accepts a beat when `in_valid & in_ready`
- `keep_matrix` in 1: sampled with the first beat of a job; 1 means the job is vector-only and reuses the loaded matrix
- `mvm_data` out B: element to multiplier `data_in`
- `mvm_loadMatrix` out 1: one-cycle pulse preceding the matrix burst
- `mvm_loadVector` out 1: one-cycle pulse preceding the vector burst
- `mvm_start` out 1: one-cycle start pulse
- `mvm_done` in 1: multiplier done
- `busy` out 1: high whenever the state is not IDLE
- `job_done` out 1: one-cycle pulse when the job completes

## Operation
- Job layout: K·K matrix elements row-major, then K vector elements; N = K·K+K elements. A vector-only job has N = K.
- States:
  - IDLE
  - FILL
  - LOADM, SENDM, GAPM
  - LOADV, SENDV, GAPV
  - START
  - WAITD
  - DRAIN
- IDLE: `in_ready`=1. On the first accepted beat:
  - write buf[0], latch keep = `keep_matrix & matrix_valid`, go to FILL (count=1).
  - If keep and K=1, go straight to LOADV.
- FILL: `in_ready`=1. Each beat writes buf[count]. When count reaches N: go to LOADM, or to LOADV if keep.
- LOADM: `mvm_loadMatrix`=1. SENDM: K·K cycles, `mvm_data`=buf[0..K·K-1]. GAPM: one idle cycle.
- LOADV: `mvm_loadVector`=1. SENDV: K cycles, `mvm_data`=buf[K·K..N-1] (buf[0..K-1] when keep). GAPV: one idle cycle.
- START: `mvm_start`=1 for one cycle, then go to WAITD.
- WAITD: wait for `mvm_done`=1, then go to DRAIN.
- DRAIN: K cycles while the multiplier streams results. Then pulse `job_done`, return to IDLE.
- `matrix_valid` is set on leaving SENDM and cleared only by reset.
- `keep_matrix`=1 while `matrix_valid`=0 is treated as a full job.
- `in_ready`=0 in every state except IDLE and FILL. Upstream holds its beat.
- `mvm_done` is ignored outside WAITD.
- Outside SENDM/SENDV, `mvm_data`=0.
- Pass-through only: no arithmetic on data, no width change.

## Timing
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, counters 0, `matrix_valid`=0. `in_ready` rises the first cycle after reset release.
- Reset mid-job (any state): outputs clear immediately (asynchronous) and the job is discarded.
- Full job, with cycle 0 = cycle of the last accepted beat:
  - `mvm_loadMatrix` at cycle 1
  - matrix data at cycles 2–17
  - gap at cycle 18
  - `mvm_loadVector` at cycle 19
  - vector data at cycles 20–23
  - gap at cycle 24
  - `mvm_start` at cycle 25
- Vector-only job: `mvm_loadVector` at cycle 1, data at 2–5, start at 7.
- `job_done` fires K+1 cycles after the cycle in which `mvm_done` is sampled high.
- Upstream gaps delay only FILL. The burst timing relative to the last beat is unchanged.

## Structure
- Package `mvm_pkg`:
  - constants `K`, `B`, `N_FULL` = K·K+K
  - state enum `feeder_state_t`
  - counter width `CNT_W` = $clog2(N_FULL+1)
- Sub-module `mvm_elem_buf`: N_FULL×B register file with one write port and one read port, no reset on storage.
- The top holds the FSM, a shared element counter and `matrix_valid`.

## Test plan
- Full job, continuous valid; matrix 1..16, vector 1,1,1,1; real `mvm_4_1_8_1` downstream. Required response: burst timing exactly as in Timing, y = 10,26,42,58, one `job_done`.
- Same data with `in_valid` high every 3rd cycle. Required response: identical burst relative to the last beat, and `in_ready` stays high throughout FILL.
- Follow-up job with `keep_matrix`=1 and vector 2,0,0,0. Required response: no `mvm_loadMatrix`, 4 beats accepted, start at cycle 7, y = 2,10,18,26.
- `keep_matrix`=1 as the first job after reset. Required response: 20 beats accepted and `mvm_loadMatrix` pulses.
- `reset` low during SENDM at element 8. Required response: all outputs 0 within the same cycle, `in_ready`=1 one cycle after release, and the next job behaves as a full job.
- `mvm_done` pulsed during IDLE and FILL. Required response: no state change; `job_done` only after the real done plus K+1 cycles.
